// File: rtl/router_ctrl_sync_if.sv
// router_ctrl_sync_if: groups the router control block's handshake, status and steering signals.
// Latency: none (wires only).
// Backpressure: carries the per-port full flags that gate write_enb.
// Ports: master = input FSM / FIFO side that drives requests and flags; slave = router_ctrl_sync.
// Optional macro ROUTER_CTRL_STATS_EN adds drop_count.
interface router_ctrl_sync_if;
    logic       detect_add;
    logic [1:0] data_in;
    logic       write_enb_reg;
    logic       pkt_done;
    logic [2:0] read_enb;
    logic [2:0] empty;
    logic [2:0] full;
    logic [2:0] write_enb;
    logic       fifo_full;
    logic [2:0] vld_out;
    logic [2:0] soft_reset;
    logic       busy;
    logic       addr_err;
    logic       abort;
`ifdef ROUTER_CTRL_STATS_EN
    logic [7:0] drop_count;
`endif

    modport master (
        output detect_add, data_in, write_enb_reg, pkt_done, read_enb, empty, full,
        input  write_enb, fifo_full, vld_out, soft_reset, busy, addr_err, abort
`ifdef ROUTER_CTRL_STATS_EN
        , input drop_count
`endif
    );

    modport slave (
        input  detect_add, data_in, write_enb_reg, pkt_done, read_enb, empty, full,
        output write_enb, fifo_full, vld_out, soft_reset, busy, addr_err, abort
`ifdef ROUTER_CTRL_STATS_EN
        , output drop_count
`endif
    );
endinterface

// File: rtl/router_ctrl_sync.sv
// router_ctrl_sync: decodes the header address and steers the write stream to one of three FIFOs.
// Latency: write_enb/fifo_full/busy/vld_out combinational; soft_reset/addr_err/abort registered, 1 cycle.
// Backpressure: write_enb to the selected port is masked while that port's full flag is set.
// Ports: clock, reset (sync, active-high); everything else via router_ctrl_sync_if.slave.
// Optional macro ROUTER_CTRL_STATS_EN adds an 8-bit saturating drop_count output.
module router_ctrl_sync #(
    parameter int TIMEOUT = 30,
    parameter int CW      = 5
) (
    input  logic              clock,
    input  logic              reset,
    router_ctrl_sync_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUTE = 2'd1,
        ABORT = 2'd2
    } state_t;

    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t        state;
    logic [1:0]    addr_reg;
    logic [CW-1:0] cnt [3];
    logic [2:0]    soft_reset_q;
    logic          addr_err_q;
    logic          abort_q;

    // Control FSM; addr_err and abort are registered one-cycle pulses.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            addr_reg   <= 2'd0;
            addr_err_q <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            addr_err_q <= 1'b0;
            abort_q    <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.detect_add) begin
                        if (bus.data_in == 2'd3) begin
                            addr_err_q <= 1'b1;
                        end else begin
                            addr_reg <= bus.data_in;
                            state    <= ROUTE;
                        end
                    end
                end
                ROUTE: begin
                    // A timeout on the port being written kills the packet, even on its last byte.
                    if (soft_reset_q[addr_reg]) begin
                        state   <= ABORT;
                        abort_q <= 1'b1;
                    end else if (bus.pkt_done) begin
                        state <= IDLE;
                    end
                end
                ABORT:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Per-port drain watchdog: counts cycles with data waiting and no read.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) cnt[i] <= '0;
            soft_reset_q <= 3'b000;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (bus.read_enb[i] || bus.empty[i]) begin
                    cnt[i]          <= '0;
                    soft_reset_q[i] <= 1'b0;
                end else if (cnt[i] == CNT_LAST) begin
                    cnt[i]          <= '0;
                    soft_reset_q[i] <= 1'b1;
                end else begin
                    cnt[i]          <= cnt[i] + CW'(1);
                    soft_reset_q[i] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        bus.write_enb = 3'b000;
        bus.fifo_full = 1'b0;
        if (state == ROUTE) begin
            bus.write_enb[addr_reg] = bus.write_enb_reg & ~bus.full[addr_reg];
            bus.fifo_full           = bus.full[addr_reg];
        end
    end

    assign bus.busy       = (state != IDLE);
    assign bus.vld_out    = ~bus.empty;
    assign bus.soft_reset = soft_reset_q;
    assign bus.addr_err   = addr_err_q;
    assign bus.abort      = abort_q;

`ifdef ROUTER_CTRL_STATS_EN
    logic [7:0] drop_q;

    // Coincident addr_err and abort pulses count as a single drop.
    always_ff @(posedge clock) begin
        if (reset) begin
            drop_q <= 8'd0;
        end else if ((addr_err_q || abort_q) && (drop_q != 8'hFF)) begin
            drop_q <= drop_q + 8'd1;
        end
    end

    assign bus.drop_count = drop_q;
`endif
endmodule

// File: tb/tb_router_ctrl_sync.sv
module tb_router_ctrl_sync;
    localparam int TIMEOUT = 30;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 1'b0;

    router_ctrl_sync_if bus ();

    router_ctrl_sync #(.TIMEOUT(TIMEOUT), .CW(5)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Behavioural model: routing target (-1 = not routing), abort-cycle flag,
    // and an unbounded idle streak per port whose every TIMEOUT-th step fires.
    int       m_port = -1;
    bit       m_in_abort = 1'b0;
    bit       m_addr_err = 1'b0;
    bit [2:0] m_sr = 3'b000;
    int       streak [3] = '{0, 0, 0};
    int       m_drop = 0;

    always @(posedge clock) begin
        bit [2:0] nsr;
        if (reset) begin
            m_port = -1; m_in_abort = 1'b0; m_addr_err = 1'b0;
            m_sr = 3'b000; m_drop = 0;
            for (int i = 0; i < 3; i++) streak[i] = 0;
        end else begin
            if ((m_addr_err || m_in_abort) && m_drop < 255) m_drop = m_drop + 1;
            nsr = 3'b000;
            for (int i = 0; i < 3; i++) begin
                if (bus.read_enb[i] || bus.empty[i]) streak[i] = 0;
                else begin
                    streak[i] = streak[i] + 1;
                    nsr[i] = (streak[i] % TIMEOUT) == 0;
                end
            end
            m_addr_err = 1'b0;
            if (m_in_abort) begin
                m_in_abort = 1'b0;
            end else if (m_port >= 0) begin
                if (m_sr[m_port]) begin
                    m_in_abort = 1'b1;
                    m_port = -1;
                end else if (bus.pkt_done) begin
                    m_port = -1;
                end
            end else if (bus.detect_add) begin
                if (bus.data_in == 2'd3) m_addr_err = 1'b1;
                else m_port = int'(bus.data_in);
            end
            m_sr = nsr;
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        logic [2:0] e_we;
        logic       e_ff;
        if (chk_en) begin
            e_we = 3'b000;
            e_ff = 1'b0;
            if (m_port >= 0) begin
                e_ff = bus.full[m_port];
                e_we[m_port] = bus.write_enb_reg & ~bus.full[m_port];
            end
            chk("model write_enb", {5'd0, bus.write_enb}, {5'd0, e_we});
            chk("model fifo_full", {7'd0, bus.fifo_full}, {7'd0, e_ff});
            chk("model vld_out", {5'd0, bus.vld_out}, {5'd0, ~bus.empty});
            chk("model soft_reset", {5'd0, bus.soft_reset}, {5'd0, m_sr});
            chk("model busy", {7'd0, bus.busy}, {7'd0, (m_port >= 0) || m_in_abort});
            chk("model addr_err", {7'd0, bus.addr_err}, {7'd0, m_addr_err});
            chk("model abort", {7'd0, bus.abort}, {7'd0, m_in_abort});
`ifdef ROUTER_CTRL_STATS_EN
            chk("model drop_count", bus.drop_count, m_drop[7:0]);
`endif
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    initial begin
        bus.detect_add = 0; bus.data_in = 0; bus.write_enb_reg = 0; bus.pkt_done = 0;
        bus.read_enb = 3'b000; bus.empty = 3'b111; bus.full = 3'b000;
        cyc(); cyc();
        reset = 0;
        chk_en = 1'b1;

        // Reset state
        @(negedge clock);
        chk("rst write_enb", {5'd0, bus.write_enb}, 8'h00);
        chk("rst busy", {7'd0, bus.busy}, 8'h00);
        chk("rst soft_reset", {5'd0, bus.soft_reset}, 8'h00);
        chk("rst vld_out", {5'd0, bus.vld_out}, 8'h00);

        // 1: route four bytes to port 1
        bus.detect_add = 1; bus.data_in = 2'd1;
        cyc();
        bus.detect_add = 0;
        for (int k = 0; k < 4; k++) begin
            bus.write_enb_reg = 1; bus.pkt_done = (k == 3);
            @(negedge clock);
            chk("t1 write_enb", {5'd0, bus.write_enb}, 8'h02);
            chk("t1 busy", {7'd0, bus.busy}, 8'h01);
            cyc();
        end
        bus.write_enb_reg = 0; bus.pkt_done = 0;
        @(negedge clock);
        chk("t1 idle busy", {7'd0, bus.busy}, 8'h00);
        chk("t1 idle write_enb", {5'd0, bus.write_enb}, 8'h00);
        cyc();

        // 2: full backpressure on port 2
        bus.detect_add = 1; bus.data_in = 2'd2;
        cyc();
        bus.detect_add = 0; bus.full = 3'b100; bus.write_enb_reg = 1;
        @(negedge clock);
        chk("t2 full write_enb", {5'd0, bus.write_enb}, 8'h00);
        chk("t2 fifo_full", {7'd0, bus.fifo_full}, 8'h01);
        cyc();
        bus.full = 3'b000;
        @(negedge clock);
        chk("t2 drain write_enb", {5'd0, bus.write_enb}, 8'h04);
        bus.pkt_done = 1;
        cyc();
        bus.pkt_done = 0; bus.write_enb_reg = 0;
        cyc();

        // 3: invalid address
        bus.detect_add = 1; bus.data_in = 2'd3;
        cyc();
        bus.detect_add = 0;
        @(negedge clock);
        chk("t3 addr_err", {7'd0, bus.addr_err}, 8'h01);
        chk("t3 busy", {7'd0, bus.busy}, 8'h00);
        cyc();
        @(negedge clock);
        chk("t3 addr_err clear", {7'd0, bus.addr_err}, 8'h00);
`ifdef ROUTER_CTRL_STATS_EN
        chk("t3 drop_count", bus.drop_count, 8'd1);
`endif

        // 4: port 0 timeout, then a read at window cycle 15 restarts it
        bus.empty = 3'b110;
        for (int e = 1; e <= 30; e++) begin
            cyc();
            @(negedge clock);
            chk("t4 sr window1", {7'd0, bus.soft_reset[0]}, {7'd0, e == 30});
        end
        for (int w = 1; w <= 45; w++) begin
            bus.read_enb[0] = (w == 15);
            cyc();
            bus.read_enb[0] = 0;
            @(negedge clock);
            chk("t4 sr window2", {7'd0, bus.soft_reset[0]}, {7'd0, w == 45});
        end
        bus.empty = 3'b111;
        cyc();

        // 5: timeout on the port being routed aborts the packet
        bus.empty = 3'b101; bus.detect_add = 1; bus.data_in = 2'd1;
        cyc();
        bus.detect_add = 0;
        for (int e = 2; e <= 30; e++) cyc();
        @(negedge clock);
        chk("t5 soft_reset", {5'd0, bus.soft_reset}, 8'h02);
        chk("t5 abort before", {7'd0, bus.abort}, 8'h00);
        bus.empty = 3'b111;
        cyc();
        @(negedge clock);
        chk("t5 abort", {7'd0, bus.abort}, 8'h01);
        chk("t5 abort busy", {7'd0, bus.busy}, 8'h01);
        cyc();
        @(negedge clock);
        chk("t5 after abort", {7'd0, bus.abort}, 8'h00);
        chk("t5 idle busy", {7'd0, bus.busy}, 8'h00);
`ifdef ROUTER_CTRL_STATS_EN
        chk("t5 drop_count", bus.drop_count, 8'd2);
`endif
        bus.detect_add = 1; bus.data_in = 2'd0;
        cyc();
        bus.detect_add = 0; bus.write_enb_reg = 1;
        @(negedge clock);
        chk("t5 new header", {5'd0, bus.write_enb}, 8'h01);
        bus.pkt_done = 1;
        cyc();
        bus.pkt_done = 0; bus.write_enb_reg = 0;
        cyc();

        // 6: reset mid-packet
        bus.detect_add = 1; bus.data_in = 2'd2; bus.empty = 3'b110;
        cyc();
        bus.detect_add = 0; bus.write_enb_reg = 1;
        cyc(); cyc();
        @(negedge clock);
        chk("t6 pre write_enb", {5'd0, bus.write_enb}, 8'h04);
        reset = 1;
        cyc();
        reset = 0;
        @(negedge clock);
        chk("t6 write_enb", {5'd0, bus.write_enb}, 8'h00);
        chk("t6 busy", {7'd0, bus.busy}, 8'h00);
        chk("t6 abort", {7'd0, bus.abort}, 8'h00);
`ifdef ROUTER_CTRL_STATS_EN
        chk("t6 drop_count", bus.drop_count, 8'd0);
`endif
        bus.write_enb_reg = 0;
        for (int e = 1; e <= 30; e++) begin
            cyc();
            @(negedge clock);
            chk("t6 counter restart", {7'd0, bus.soft_reset[0]}, {7'd0, e == 30});
        end
        bus.empty = 3'b111;
        cyc();
        @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/router_ctrl_sync.md
Name: router_ctrl_sync

Overview:
Control/synchronizer block for the 1-to-3 router. It decodes the destination address from the packet header and steers the single input write stream to one of three output FIFOs. It reports per-port valid and full status, and issues per-port soft resets when an output is not drained within a timeout window. It sits between the router input FSM/register stage and the three output FIFOs.

Parameters:
TIMEOUT, 30, qualifying idle cycles before an output port's soft_reset fires (valid range 2..2**CW-1)
CW, 5, width of each per-port timeout counter

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
detect_add  input  1  header-byte strobe from input FSM
data_in  input  2  destination address, data_in[1:0] of header byte
write_enb_reg  input  1  payload write request from input FSM
pkt_done  input  1  last byte of current packet written
read_enb  input  3  per-port read strobe from downstream, bit i = port i
empty  input  3  per-port FIFO empty flags
full  input  3  per-port FIFO full flags
write_enb  output  3  one-hot FIFO write enables
fifo_full  output  1  full flag of currently selected port
vld_out  output  3  per-port data valid
soft_reset  output  3  per-port one-cycle soft reset pulse
busy  output  1  high while a packet is being routed
addr_err  output  1  one-cycle pulse on invalid header address
abort  output  1  one-cycle pulse when active packet is killed by soft reset

Behaviour:
- Reset: synchronous, active-high, sampled on clock rising edge. Sets state=IDLE, addr_reg=0, all counters=0, soft_reset=0, addr_err=0, abort=0. Combinational outputs follow from these values: write_enb=0, fifo_full=0, busy=0, vld_out=~empty.
- FSM states: IDLE, ROUTE, ABORT (2-bit encoding).
- IDLE:
  - detect_add=1 with data_in in {0,1,2}: addr_reg<=data_in, next state ROUTE.
  - detect_add=1 with data_in==3: addr_err=1 for the next cycle, stay in IDLE.
- ROUTE:
  - busy=1.
  - write_enb[addr_reg] = write_enb_reg & ~full[addr_reg]; all other bits 0.
  - fifo_full = full[addr_reg].
  - pkt_done=1 -> IDLE.
  - soft_reset[addr_reg] rising (registered) -> ABORT; this takes priority over pkt_done in the same cycle.
  - detect_add is ignored in ROUTE.
- ABORT: lasts one cycle. abort=1, write_enb=0, busy=1, then -> IDLE.
- In IDLE and ABORT: write_enb=0, fifo_full=0.
- vld_out[i] = ~empty[i]; combinational, no latency.
- Timeout counter i (CW bits), per port:
  - Qualifying condition: vld_out[i] & ~read_enb[i].
  - read_enb[i]=1 or empty[i]=1: cnt<=0.
  - Else, cnt==TIMEOUT-1: soft_reset[i]<=1 and cnt<=0.
  - Else: cnt<=cnt+1.
  - soft_reset[i] is 0 in every other cycle, so it is a strict one-cycle pulse.
  - Counters never wrap past TIMEOUT-1.
- Latency: soft_reset[i] is high in the cycle after the TIMEOUT-th consecutive qualifying edge.
- Simultaneous soft resets on several ports are independent; only the selected port triggers ABORT.
- reset asserted mid-packet returns to IDLE on the next edge; no abort pulse is generated.

Optional Feature:
Macro ROUTER_CTRL_STATS_EN.
- Defined: adds output drop_count [7:0], a saturating counter (holds at 255) incremented on every addr_err or abort pulse. Both pulses in the same cycle add 1. Cleared by reset.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
1. Reset, then detect_add=1, data_in=2'b01; write_enb_reg=1 for 4 cycles; pkt_done on 4th -> write_enb=3'b010 for 4 cycles, busy=1 throughout, then IDLE with busy=0.
2. In ROUTE to port 2 with full=3'b100, write_enb_reg=1 -> write_enb=0, fifo_full=1. Deassert full[2] -> write_enb=3'b100 next cycle.
3. detect_add=1, data_in=2'b11 -> addr_err high exactly 1 cycle, state stays IDLE, write_enb stays 0. With ROUTER_CTRL_STATS_EN, drop_count=1.
4. empty[0]=0, read_enb[0]=0 held 30 cycles -> soft_reset[0] high for exactly 1 cycle after the 30th edge. Then read_enb[0] pulsed at cycle 15 of a new window -> no soft_reset through cycle 44.
5. Routing to port 1 while its timeout expires -> soft_reset[1] pulse, then ABORT with abort=1 for 1 cycle, then IDLE. A new header is accepted afterwards.
6. Assert reset mid-ROUTE with write_enb_reg=1 -> next edge write_enb=0, busy=0, counters 0, no abort pulse.
